// File: rtl/sync_decoder.sv
// Purpose: regenerate beam position and line/frame lengths from HSYNC/VSYNC; track horizontal lock.
// Latency: outputs register one main_clk after the cck_ena cycle that samples the sync edge.
// Backpressure: none; the block advances only on cck_ena and holds state otherwise.
module sync_decoder #(
    parameter int LOCK_LINES = 4,
    parameter int HLEN_MIN   = 226,
    parameter int HLEN_MAX   = 228
) (
    input  logic        main_clk,
    input  logic        main_rst,
    input  logic        cck_ena,
    input  logic        HSYNC,
    input  logic        VSYNC,
    output logic [8:0]  HPOS,
    output logic [10:0] VPOS,
    output logic [8:0]  LINE_LEN,
    output logic [10:0] FRAME_LEN,
    output logic        HS_PULSE,
    output logic        LOCKED,
    output logic        NTSC_DET,
    output logic        LONG_FRAME
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam logic [8:0] HMIN     = HLEN_MIN[8:0];
    localparam logic [8:0] HMAX     = HLEN_MAX[8:0];
    localparam logic [2:0] LOCK_CNT = LOCK_LINES[2:0];

    // Previous sync samples; held at 1 by reset so an idle-high input never looks like an edge.
    logic        hs_q;
    logic        vs_q;
    // Set once the first (partial) line has been aligned; lines before that are not judged.
    logic        first_seen;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic [2:0]  cnt_inc;

    logic        hs_fall;
    logic        vs_fall;
    logic [9:0]  hpos_inc;
    logic [8:0]  hpos_sat;
    logic [11:0] vpos_inc;
    logic [10:0] vpos_sat;
    logic        line_ok;

    // Edge detection and saturating position arithmetic shared by datapath and FSM.
    always_comb begin
        hs_fall  = cck_ena & hs_q & ~HSYNC;
        vs_fall  = cck_ena & vs_q & ~VSYNC;
        hpos_inc = {1'b0, HPOS} + 10'd1;
        hpos_sat = hpos_inc[9] ? 9'h1FF : hpos_inc[8:0];
        vpos_inc = {1'b0, VPOS} + 12'd1;
        vpos_sat = vpos_inc[11] ? 11'h7FF : vpos_inc[10:0];
        line_ok  = (hpos_sat >= HMIN) && (hpos_sat <= HMAX);
        cnt_inc  = cnt + 3'd1;
    end

    // Lock FSM next state: judge each completed line, and drop lock when HSYNC goes missing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (hs_fall && first_seen) begin
            case (state)
                ST_UNLOCKED: begin
                    if (line_ok) begin
                        cnt_nxt   = 3'd1;
                        state_nxt = (LOCK_CNT <= 3'd1) ? ST_LOCKED : ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (line_ok) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= LOCK_CNT) begin
                            state_nxt = ST_LOCKED;
                        end
                    end else begin
                        cnt_nxt   = 3'd0;
                        state_nxt = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!line_ok) begin
                        cnt_nxt   = 3'd0;
                        state_nxt = ST_UNLOCKED;
                    end
                end
                default: begin
                    cnt_nxt   = 3'd0;
                    state_nxt = ST_UNLOCKED;
                end
            endcase
        end else if (cck_ena && (state == ST_LOCKED) && (HPOS == 9'h1FF)) begin
            cnt_nxt   = 3'd0;
            state_nxt = ST_UNLOCKED;
        end
    end

    // Lock FSM state and its registered LOCKED flag, updated together.
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            state  <= ST_UNLOCKED;
            cnt    <= 3'd0;
            LOCKED <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            LOCKED <= (state_nxt == ST_LOCKED);
        end
    end

    // Sync sampling, position counters and line/frame measurements; VSYNC wins over the line increment.
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            first_seen <= 1'b0;
            HPOS       <= 9'd0;
            VPOS       <= 11'd0;
            LINE_LEN   <= 9'd0;
            FRAME_LEN  <= 11'd0;
            HS_PULSE   <= 1'b0;
            NTSC_DET   <= 1'b0;
            LONG_FRAME <= 1'b0;
        end else begin
            HS_PULSE <= hs_fall;
            if (cck_ena) begin
                hs_q <= HSYNC;
                vs_q <= VSYNC;
                if (hs_fall) begin
                    LINE_LEN   <= hpos_sat;
                    HPOS       <= 9'd0;
                    first_seen <= 1'b1;
                end else begin
                    HPOS <= hpos_sat;
                end
                if (vs_fall) begin
                    FRAME_LEN  <= vpos_sat;
                    VPOS       <= 11'd0;
                    NTSC_DET   <= (vpos_inc < 12'd288);
                    LONG_FRAME <= vpos_inc[0];
                end else if (hs_fall) begin
                    VPOS <= vpos_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_decoder.sv
// Purpose: randomized self-checking bench for sync_decoder with a line-level reference model.
// Latency: expectations are queued per HSYNC edge and popped when HS_PULSE appears.
// Backpressure: none; cck_ena spacing is randomized between one and two main_clk cycles.
module tb_sync_decoder;

    localparam int LOCK_LINES = 4;
    localparam int HLEN_MIN   = 226;
    localparam int HLEN_MAX   = 228;

    logic        main_clk = 1'b0;
    logic        main_rst;
    logic        cck_ena;
    logic        HSYNC;
    logic        VSYNC;
    logic [8:0]  HPOS;
    logic [10:0] VPOS;
    logic [8:0]  LINE_LEN;
    logic [10:0] FRAME_LEN;
    logic        HS_PULSE;
    logic        LOCKED;
    logic        NTSC_DET;
    logic        LONG_FRAME;

    sync_decoder #(
        .LOCK_LINES(LOCK_LINES),
        .HLEN_MIN  (HLEN_MIN),
        .HLEN_MAX  (HLEN_MAX)
    ) dut (
        .main_clk  (main_clk),
        .main_rst  (main_rst),
        .cck_ena   (cck_ena),
        .HSYNC     (HSYNC),
        .VSYNC     (VSYNC),
        .HPOS      (HPOS),
        .VPOS      (VPOS),
        .LINE_LEN  (LINE_LEN),
        .FRAME_LEN (FRAME_LEN),
        .HS_PULSE  (HS_PULSE),
        .LOCKED    (LOCKED),
        .NTSC_DET  (NTSC_DET),
        .LONG_FRAME(LONG_FRAME)
    );

    always #5 main_clk = ~main_clk;

    typedef struct {
        int line_len;
        int vpos;
        int frame_len;
        int ntsc;
        int lng;
        int locked;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state, expressed in whole lines and colour clocks.
    int   span;       // colour clocks since the last HSYNC edge, counting the edge itself as 1
    int   m_vpos;     // lines since the last VSYNC edge
    int   m_frame;
    int   m_ntsc;
    int   m_lng;
    int   run;        // consecutive in-range judged lines
    bit   seen;       // first edge after reset already consumed

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    task automatic model_reset();
        span    = 1;
        m_vpos  = 0;
        m_frame = 0;
        m_ntsc  = 0;
        m_lng   = 0;
        run     = 0;
        seen    = 0;
    endtask

    // Model reaction to one HSYNC edge (optionally coinciding with a VSYNC edge).
    task automatic model_edge(input bit vs);
        exp_t e;
        int   meas;
        meas = (span > 511) ? 511 : span;
        if (seen) begin
            if (meas >= HLEN_MIN && meas <= HLEN_MAX) run++;
            else run = 0;
        end
        seen = 1;
        if (vs) begin
            m_frame = (m_vpos + 1 > 2047) ? 2047 : m_vpos + 1;
            m_ntsc  = (m_vpos + 1 < 288) ? 1 : 0;
            m_lng   = (m_vpos + 1) % 2;
            m_vpos  = 0;
        end else begin
            m_vpos = (m_vpos + 1 > 2047) ? 2047 : m_vpos + 1;
        end
        span        = 1;
        e.line_len  = meas;
        e.vpos      = m_vpos;
        e.frame_len = m_frame;
        e.ntsc      = m_ntsc;
        e.lng       = m_lng;
        e.locked    = (run >= LOCK_LINES) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic model_tick();
        span++;
        if (span >= 512) run = 0;
    endtask

    // One colour clock: present syncs with cck_ena high for a single main_clk, then an optional gap.
    task automatic cck(input logic hs, input logic vs);
        HSYNC   = hs;
        VSYNC   = vs;
        cck_ena = 1'b1;
        @(posedge main_clk); #1;
        cck_ena = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge main_clk); #1;
        end
    endtask

    // A line of len colour clocks starting with the HSYNC falling edge (syncs low for 8 clocks).
    task automatic send_line(input int len, input bit vs);
        model_edge(vs);
        for (int i = 0; i < len; i++) begin
            cck((i < 8) ? 1'b0 : 1'b1, (vs && i < 8) ? 1'b0 : 1'b1);
            if (i > 0) model_tick();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cck(1'b1, 1'b1);
            model_tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_hpos"},       int'(HPOS),       0);
        chk({tag, "_vpos"},       int'(VPOS),       0);
        chk({tag, "_line_len"},   int'(LINE_LEN),   0);
        chk({tag, "_frame_len"},  int'(FRAME_LEN),  0);
        chk({tag, "_hs_pulse"},   int'(HS_PULSE),   0);
        chk({tag, "_locked"},     int'(LOCKED),     0);
        chk({tag, "_ntsc_det"},   int'(NTSC_DET),   0);
        chk({tag, "_long_frame"}, int'(LONG_FRAME), 0);
    endtask

    // Monitor: every HS_PULSE cycle consumes exactly one queued expectation.
    always @(negedge main_clk) begin
        if (HS_PULSE) begin
            if (q.size() == 0) begin
                chk("unexpected_hs_pulse", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("line_len",   int'(LINE_LEN),   e.line_len);
                chk("vpos",       int'(VPOS),       e.vpos);
                chk("hpos_at_edge", int'(HPOS),     0);
                chk("frame_len",  int'(FRAME_LEN),  e.frame_len);
                chk("ntsc_det",   int'(NTSC_DET),   e.ntsc);
                chk("long_frame", int'(LONG_FRAME), e.lng);
                chk("locked",     int'(LOCKED),     e.locked);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        main_rst = 1'b1;
        cck_ena  = 1'b1;
        HSYNC    = 1'b1;
        VSYNC    = 1'b1;
        model_reset();
        repeat (3) @(posedge main_clk);
        @(negedge main_clk);
        check_all_zero("reset");
        @(posedge main_clk); #1;
        main_rst = 1'b0;
        cck_ena  = 1'b0;

        // Partial first line, then steady 227-CCK lines: lock on the 4th judged edge.
        idle(37);
        for (int i = 0; i < 8; i++) send_line(227, 1'b0);

        // NTSC-style alternating lengths keep lock.
        for (int i = 0; i < 12; i++) send_line((i % 2 == 0) ? 228 : 227, 1'b0);

        // One short line drops lock; four good lines regain it.
        send_line(200, 1'b0);
        for (int i = 0; i < 6; i++) send_line(227, 1'b0);

        // HSYNC stuck high: HPOS saturates, lock drops, VPOS holds.
        send_line(9, 1'b0);
        idle(600);
        @(negedge main_clk);
        chk("stuck_hpos",   int'(HPOS),   511);
        chk("stuck_locked", int'(LOCKED), 0);
        chk("stuck_vpos",   int'(VPOS),   m_vpos);
        @(posedge main_clk); #1;
        for (int i = 0; i < 6; i++) send_line(227, 1'b0);

        // Frame lengths: align, then a 263-line frame and a 312-line frame, then VPOS=100 coincidence.
        send_line(16, 1'b1);
        for (int i = 0; i < 262; i++) send_line(16, 1'b0);
        send_line(16, 1'b1);
        for (int i = 0; i < 311; i++) send_line(16, 1'b0);
        send_line(16, 1'b1);
        for (int i = 0; i < 100; i++) send_line(16, 1'b0);
        send_line(16, 1'b1);

        // Randomized mix of in-range, near-range and odd line lengths with occasional VSYNC.
        for (int i = 0; i < 24; i++) begin
            int r;
            int len;
            r   = int'($urandom_range(0, 4));
            len = (r < 3) ? 226 + r : ((r == 3) ? 229 : int'($urandom_range(16, 300)));
            send_line(len, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        // Reset mid-line with cck_ena and a falling HSYNC present: reset wins.
        idle(50);
        main_rst = 1'b1;
        cck_ena  = 1'b1;
        HSYNC    = 1'b0;
        @(posedge main_clk); #1;
        main_rst = 1'b0;
        cck_ena  = 1'b0;
        HSYNC    = 1'b1;
        model_reset();
        @(negedge main_clk);
        check_all_zero("midline_reset");
        @(posedge main_clk); #1;

        // Decoder works normally after the mid-line reset.
        idle(5);
        for (int i = 0; i < 6; i++) send_line(227, 1'b0);
        idle(3);
        repeat (4) @(posedge main_clk);
        @(negedge main_clk);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_decoder.md
SYNC_DECODER -- requirements
Module: sync_decoder

Interface
REQ-001 SHALL have parameter LOCK_LINES, default 4: consecutive in-range line lengths needed to assert LOCKED.
REQ-002 SHALL have parameter HLEN_MIN, default 226: minimum valid line length in CCK cycles.
REQ-003 SHALL have parameter HLEN_MAX, default 228: maximum valid line length in CCK cycles.
REQ-004 SHALL have port main_clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port main_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cck_ena  input  1  CCK rising-edge enable, one main_clk-wide pulse per colour clock.
REQ-007 SHALL have port HSYNC  input  1  horizontal sync from the beam generator, active-low.
REQ-008 SHALL have port VSYNC  input  1  vertical sync from the beam generator, active-low.
REQ-009 SHALL have port HPOS  output  9  regenerated horizontal position in CCK cycles.
REQ-010 SHALL have port VPOS  output  11  regenerated vertical position in lines.
REQ-011 SHALL have port LINE_LEN  output  9  length of the last completed line.
REQ-012 SHALL have port FRAME_LEN  output  11  line count of the last completed frame.
REQ-013 SHALL have port HS_PULSE  output  1  one main_clk pulse per detected HSYNC falling edge.
REQ-014 SHALL have port LOCKED  output  1  horizontal lock indicator.
REQ-015 SHALL have port NTSC_DET  output  1  1 when the last frame was NTSC-length.
REQ-016 SHALL have port LONG_FRAME  output  1  1 when the last frame had an odd line count.

Function
REQ-017 SHALL sample HSYNC and VSYNC into one register each only when cck_ena=1; all state SHALL hold when cck_ena=0.
REQ-018 SHALL detect a falling edge as previous sample 1 and current input 0, both evaluated on the same cck_ena cycle.
REQ-019 SHALL increment HPOS by 1 per cck_ena, saturating at 511 (no wrap).
REQ-020 On HSYNC falling edge SHALL load LINE_LEN with HPOS+1 (saturated at 511), set HPOS to 0, and pulse HS_PULSE for that single main_clk cycle.
REQ-021 On HSYNC falling edge SHALL increment VPOS by 1, saturating at 2047.
REQ-022 On VSYNC falling edge SHALL load FRAME_LEN with VPOS+1 (saturated at 2047) and set VPOS to 0; it SHALL take priority over the REQ-021 increment when both edges coincide.
REQ-023 On VSYNC falling edge SHALL set NTSC_DET=1 if VPOS+1 < 288, else 0, and set LONG_FRAME to bit 0 of VPOS+1.
REQ-024 Lock FSM states: UNLOCKED, ACQUIRE, LOCKED; a 3-bit qualified-line counter SHALL exist alongside.
REQ-025 UNLOCKED: on an in-range line (HLEN_MIN <= measured length <= HLEN_MAX) go to ACQUIRE with counter=1; out-of-range stays UNLOCKED.
REQ-026 ACQUIRE: in-range line increments counter, entering LOCKED when counter reaches LOCK_LINES; out-of-range line returns to UNLOCKED with counter=0.
REQ-027 LOCKED: out-of-range line returns to UNLOCKED; HPOS reaching 511 (lost HSYNC) SHALL also return to UNLOCKED.
REQ-028 LOCKED output SHALL be 1 only in state LOCKED, registered, changing in the same cycle as the FSM state.
REQ-029 The first HSYNC falling edge after reset SHALL only align HPOS and SHALL NOT be qualified by the FSM (partial line).
REQ-030 An HSYNC held low SHALL produce exactly one edge; HS_PULSE SHALL never exceed one main_clk cycle.

Reset
REQ-031 When main_rst=1 on a main_clk edge: HPOS=0, VPOS=0, LINE_LEN=0, FRAME_LEN=0, HS_PULSE=0, LOCKED=0, NTSC_DET=0, LONG_FRAME=0, FSM=UNLOCKED, counter=0.
REQ-032 Reset SHALL set the sync sample registers to 1 so no spurious edge follows reset; reset SHALL override cck_ena and any mid-line or mid-frame state.

Verification
REQ-033 Scenario: HSYNC falls every 227 CCKs, after first edge -> LINE_LEN=227 each line, LOCKED=1 at the 4th qualified edge.
REQ-034 Scenario: NTSC alternating 227/228 lines, VSYNC every 263 lines -> LOCKED stays 1, FRAME_LEN=263, NTSC_DET=1, LONG_FRAME=1.
REQ-035 Scenario: PAL 227-CCK lines, VSYNC every 312 lines -> FRAME_LEN=312, NTSC_DET=0, LONG_FRAME=0.
REQ-036 Scenario: locked, then one line of 200 CCKs -> LOCKED=0 at that edge; 4 subsequent 227 lines -> LOCKED=1.
REQ-037 Scenario: locked, HSYNC stuck high -> HPOS saturates at 511, LOCKED=0, VPOS unchanged.
REQ-038 Scenario: HSYNC and VSYNC fall on same cck_ena with VPOS=100 -> FRAME_LEN=101, VPOS=0, HPOS=0; main_rst asserted mid-line -> all outputs per REQ-031 next cycle.
